div_unit: RTL and testbench

- Multi-cycle RV32M divider in the EX stage, between register-file read and writeback.
- Consumes the two source operands read from the register file and executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm.
- Delivers the result, destination address and write-enable straight to the register-file write port.
- Asserts busy so the pipeline control stalls issue while a divide is in flight.

---
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle. Signs are fixed up once, in DONE. The write-port outputs are
// registered, so the strobe appears on the edge that leaves DONE.
module div_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  busy,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]       quo, rem, dvsr;
  logic [CW-1:0]         count;
  logic                  sel_rem, neg_q, neg_r, bypass;
  logic [REG_ADDR_W-1:0] addr_q;

  logic                  sgn, div_zero, ovf, accept, last;
  logic [XLEN-1:0]       a_mag, b_mag, q_res, r_res;
  logic [XLEN:0]         trial;

  // Acceptance-time decode of the incoming operands.
  assign sgn      = ~op[0];
  assign a_mag    = (sgn && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
  assign b_mag    = (sgn && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  assign ovf      = sgn && (rs1_data == INT_MIN) && (rs2_data == '1);
  assign accept   = start && !flush;
  assign last     = (count == CW'(XLEN-1));

  // Shift {rem,quo} left by one and try to subtract the divisor from the top.
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvsr};

  // Special-case results were loaded pre-signed, so they skip the sign fix.
  assign q_res = (neg_q && !bypass) ? -quo : quo;
  assign r_res = (neg_r && !bypass) ? -rem : rem;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush wins over normal progress in CALC and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
      CALC: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and write port: latch on accept, iterate in CALC, write from DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      count   <= '0;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      bypass  <= 1'b0;
      addr_q  <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sel_rem <= op[1];
            addr_q  <= rd_addr;
            neg_q   <= sgn && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
            neg_r   <= sgn && rs1_data[XLEN-1];
            dvsr    <= b_mag;
            count   <= '0;
            if (div_zero) begin
              quo    <= '1;
              rem    <= rs1_data;
              bypass <= 1'b1;
            end else if (ovf) begin
              quo    <= INT_MIN;
              rem    <= '0;
              bypass <= 1'b1;
            end else begin
              quo    <= a_mag;
              rem    <= '0;
              bypass <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= {rem[XLEN-2:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (!flush) begin
            we    <= 1'b1;
            waddr <= addr_q;
            wdata <= sel_rem ? r_res : q_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an
// arithmetic reference model of the RV32M divide rules.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int tests = 0;
  int fails = 0;

  div_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one operation and check latency, busy duration, result and hold.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input bit hold_start);
    logic [31:0] exp;
    int edges, busy_cnt, pulses;
    bit special;
    exp = model(o, a, b);
    special = is_special(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    edges = 0; busy_cnt = 0; pulses = 0;
    while (pulses == 0 && edges < 60) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
      if (we) pulses++;
    end
    start = 1'b0;
    check({tag, " we_seen"}, 32'(pulses), 32'd1);
    check({tag, " latency"}, 32'(edges), special ? 32'd1 : 32'd33);
    check({tag, " busy_cycles"}, 32'(busy_cnt), special ? 32'd1 : 32'd33);
    check({tag, " wdata"}, wdata, exp);
    check({tag, " waddr"}, 32'(waddr), 32'(rd));
    @(posedge clk); #1;
    check({tag, " we_drop"}, 32'(we), 32'd0);
    check({tag, " wdata_hold"}, wdata, exp);
    if (hold_start) begin
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        if (we || busy) pulses++;
        @(posedge clk); #1;
      end
      check({tag, " no_extra"}, 32'(pulses), 32'd0);
    end
  endtask

  // Start a DIVU, raise flush for the edge at `at_edge` after acceptance.
  task automatic run_flush(input string tag, input int at_edge);
    int pulses;
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < at_edge; i++) begin @(posedge clk); #1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check({tag, " busy_after_flush"}, 32'(busy), 32'd0);
    check({tag, " we_after_flush"}, 32'(we), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (we) pulses++;
    end
    check({tag, " no_write"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset we", 32'(we), 32'd0);
    check("reset waddr", 32'(waddr), 32'd0);
    check("reset wdata", wdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 1'b0);
    run("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 1'b0);
    check("remu literal", wdata, 32'd2);
    run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
    check("div literal", wdata, 32'hFFFF_FFFD);
    run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
    run("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 1'b0);
    run("divu_by0", 2'b01, 32'h1234, 32'd0, 5'd6, 1'b0);
    run("rem_by0", 2'b10, 32'h1234, 32'd0, 5'd7, 1'b0);
    run("div_neg_by0", 2'b00, 32'hFFFF_FF00, 32'd0, 5'd7, 1'b0);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd1, 1'b0);
    run("rd_x0", 2'b01, 32'd50, 32'd5, 5'd0, 1'b0);

    run_flush("flush_calc10", 10);
    run("after_flush_calc", 2'b01, 32'd9, 32'd3, 5'd2, 1'b0);
    run_flush("flush_done", 33);
    run("after_flush_done", 2'b01, 32'd9, 32'd3, 5'd2, 1'b0);

    // flush in IDLE blocks a simultaneous start
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_blocks", 32'(busy), 32'd0);

    run("hold_start", 2'b01, 32'd77, 32'd11, 5'd12, 1'b1);

    // reset mid-CALC clears everything
    @(negedge clk); start = 1'b1; op = 2'b01; rs1_data = 32'd500; rs2_data = 32'd3; rd_addr = 5'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid we", 32'(we), 32'd0);
    check("rst_mid waddr", 32'(waddr), 32'd0);
    check("rst_mid wdata", wdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    run("after_rst", 2'b01, 32'd9, 32'd3, 5'd2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom);
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        3: r_b = r_b >> $urandom_range(8, 28);
        default: ;
      endcase
      run($sformatf("rand%0d", i), r_op, r_a, r_b, 5'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
